// File: rtl/mux2_pkg.sv
// Shared constants and reference helpers for the mux2 block family.
// The helpers work on MUX2_MAX_W-bit operands so benches and models can zero-extend any legal width.
package mux2_pkg;

    localparam int MUX2_DEFAULT_WIDTH = 4;
    localparam int MUX2_DEFAULT_CNT_W = 8;
    localparam int MUX2_MAX_W         = 64;

    // Two-source word select with ternary semantics (an unknown select merges agreeing bits).
    function automatic logic [MUX2_MAX_W-1:0] mux2_sel(
        input logic [MUX2_MAX_W-1:0] a,
        input logic [MUX2_MAX_W-1:0] b,
        input logic                  s
    );
        return s ? b : a;
    endfunction

    // XOR-reduction parity: 1 when the word holds an odd number of ones.
    function automatic logic mux2_even_par(input logic [MUX2_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mux2_if.sv
// Bus bundle for mux2_core: data inputs, select and the observed outputs.
// The y_par wire exists only when MUX2_PARITY_EN is defined.
interface mux2_if
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEFAULT_WIDTH,
    parameter int CNT_W = MUX2_DEFAULT_CNT_W
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] sel_b_cnt;
`ifdef MUX2_PARITY_EN
    logic             y_par;
`endif

    modport master (
        output a, b, s,
`ifdef MUX2_PARITY_EN
        input  y_par,
`endif
        input  y, y_q, sel_b_cnt
    );

    modport slave (
        input  a, b, s,
`ifdef MUX2_PARITY_EN
        output y_par,
`endif
        output y, y_q, sel_b_cnt
    );

endinterface

// File: rtl/mux2_core.sv
// Parameterised 2:1 word mux with a registered copy of the output and a saturating b-select counter.
// Optional build macro MUX2_PARITY_EN adds the combinational parity output y_par.
module mux2_core
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEFAULT_WIDTH,
    parameter int CNT_W = MUX2_DEFAULT_CNT_W
) (
    input logic  clk,
    input logic  rst_n,
    mux2_if.slave bus
);

    generate
        if (WIDTH < 1 || CNT_W < 1 || WIDTH > MUX2_MAX_W) begin : g_bad_cfg
            $error("mux2_core: WIDTH must be 1..64 and CNT_W must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] y_q_r;
    logic [CNT_W-1:0] cnt_r;

    // The select itself: purely combinational, valid regardless of clock or reset.
    assign bus.y = bus.s ? bus.b : bus.a;

    // Registered copy of the selected word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r <= '0;
        end else begin
            y_q_r <= bus.y;
        end
    end

    // Count edges with s=1, holding at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (bus.s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.y_q       = y_q_r;
    assign bus.sel_b_cnt = cnt_r;

`ifdef MUX2_PARITY_EN
    logic [MUX2_MAX_W-1:0] y_ext_s;

    // Zero-extend y so the shared parity helper can be reused at any width.
    always_comb begin
        y_ext_s            = '0;
        y_ext_s[WIDTH-1:0] = bus.y;
    end

    assign bus.y_par = mux2_even_par(y_ext_s);
`endif

endmodule

// File: tb/tb_mux2_core.sv
// Directed self-checking bench for mux2_core: select sweep, latency, reset, saturation, parity.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_mux2_core;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    mux2_if #(.WIDTH(4), .CNT_W(8)) bus_m ();
    mux2_if #(.WIDTH(4), .CNT_W(2)) bus_n ();

    mux2_core #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    mux2_core #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed select vectors: a, b, s and the hand-computed y.
    logic [3:0] va [16] = '{4'h5, 4'h5, 4'h0, 4'h0, 4'hF, 4'hF, 4'h3, 4'h9,
                            4'h1, 4'hE, 4'h2, 4'hB, 4'h6, 4'h8, 4'h7, 4'hC};
    logic [3:0] vb [16] = '{4'hA, 4'hA, 4'hF, 4'hF, 4'h0, 4'h0, 4'hC, 4'h6,
                            4'h8, 4'h7, 4'h4, 4'hD, 4'h9, 4'h1, 4'hE, 4'h3};
    logic       vs [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] vy [16] = '{4'h5, 4'hA, 4'h0, 4'hF, 4'hF, 4'h0, 4'hC, 4'h9,
                            4'h8, 4'hE, 4'h4, 4'hB, 4'h9, 4'h8, 4'hE, 4'hC};
    logic [7:0] sat_exp [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s);
        bus_m.a = a;
        bus_m.b = b;
        bus_m.s = s;
        bus_n.a = a;
        bus_n.b = b;
        bus_n.s = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(4'h5, 4'hA, 1'b0);

        // Reset state, and y valid while in reset.
        #3;
        check_val("rst_y_q", 8'(bus_m.y_q), 8'h00);
        check_val("rst_cnt", 8'(bus_m.sel_b_cnt), 8'h00);
        check_val("rst_cnt_sat", 8'(bus_n.sel_b_cnt), 8'h00);
        check_val("rst_y", 8'(bus_m.y), 8'h05);

        @(negedge clk);
        rst_n = 1'b1;

        // Sweep: y checked 1 time unit after the change, y_q one rising edge later.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_val($sformatf("y_q_%0d", i - 1), 8'(bus_m.y_q), 8'(vy[i-1]));
            end
            drive(va[i], vb[i], vs[i]);
            #1;
            check_val($sformatf("y_%0d", i), 8'(bus_m.y), 8'(vy[i]));
        end
        @(negedge clk);
        check_val("y_q_15", 8'(bus_m.y_q), 8'h0C);
        check_val("cnt_sweep", 8'(bus_m.sel_b_cnt), 8'd8);
        check_val("cnt_sat_sweep", 8'(bus_n.sel_b_cnt), 8'd3);

        // Asynchronous reset mid-run, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_y_q", 8'(bus_m.y_q), 8'h00);
        check_val("mid_rst_cnt", 8'(bus_m.sel_b_cnt), 8'h00);
        check_val("mid_rst_cnt_sat", 8'(bus_n.sel_b_cnt), 8'h00);
        drive(4'h6, 4'h9, 1'b1);
        #1;
        check_val("mid_rst_y", 8'(bus_m.y), 8'h09);
        @(negedge clk);
        check_val("held_rst_cnt", 8'(bus_m.sel_b_cnt), 8'h00);
        check_val("held_rst_y_q", 8'(bus_m.y_q), 8'h00);

        // Release and hold s=1: counter restarts from zero, narrow one saturates at 3.
        rst_n = 1'b1;
        drive(4'h3, 4'hC, 1'b1);
        #1;
        check_val("lat_y", 8'(bus_m.y), 8'h0C);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("sat_cnt_%0d", i), 8'(bus_n.sel_b_cnt), sat_exp[i]);
            check_val($sformatf("run_cnt_%0d", i), 8'(bus_m.sel_b_cnt), 8'(i + 1));
        end
        check_val("lat_y_q", 8'(bus_m.y_q), 8'h0C);

        // Equal inputs are immune to the select value.
        drive(4'hF, 4'hF, 1'b0);
        #1;
        check_val("eq_s0", 8'(bus_m.y), 8'h0F);
        drive(4'hF, 4'hF, 1'b1);
        #1;
        check_val("eq_s1", 8'(bus_m.y), 8'h0F);
        drive(4'hF, 4'hF, 1'bx);
        #1;
        check_val("eq_sx", 8'(bus_m.y), 8'h0F);

`ifdef MUX2_PARITY_EN
        drive(4'h7, 4'h6, 1'b0);
        #1;
        check_val("par_odd", 8'(bus_m.y_par), 8'h01);
        drive(4'h7, 4'h6, 1'b1);
        #1;
        check_val("par_even", 8'(bus_m.y_par), 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
